// File: rtl/axis8_to_stream16_if.sv
// Byte-stream input and 16-bit word output bundle for axis8_to_stream16.
// The slave modport is the design's view; the master modport is the environment's view.
interface axis8_to_stream16_if;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;

    // Valid/ready: a transfer happens on a rising CORE_CLK edge where valid and
    // ready are both high; valid never depends combinationally on ready.
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, dout_ready,
        output s_axis_tready, dout, dout_valid, dout_last
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, dout_ready,
        input  s_axis_tready, dout, dout_valid, dout_last
    );
endinterface

// File: rtl/axis8_to_stream16.sv
// Reassembles AXIS 8-bit byte pairs (low byte first) into 16-bit words with a last flag, via a show-ahead FIFO.
// Optional macro AXIS8_UNPACK_PAD_EN: an odd trailing byte is pushed as {8'h00, byte} instead of dropped.
module axis8_to_stream16 #(
    parameter int DEPTH    = 16,
    parameter int CNT_BITS = 16
) (
    input  logic                     CORE_CLK,
    input  logic                     CORE_RSTN,
    axis8_to_stream16_if.slave       bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_BITS-1:0]      word_count,
    output logic [CNT_BITS-1:0]      pkt_count,
    output logic                     err_odd,
    output logic                     state_dbg
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {ST_LO = 1'b0, ST_HI = 1'b1} asm_state_t;

    asm_state_t    state_q, state_d;
    logic [7:0]    lo_byte_q;
    logic [16:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          full, empty, accept, pop;
    logic          lo_load, push, odd_evt;
    logic [16:0]   push_data;
    logic [16:0]   head;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // tready only depends on FIFO room, so an accepted high byte always has a slot.
    assign bus.s_axis_tready = CORE_RSTN & ~full;
    assign accept            = bus.s_axis_tvalid & bus.s_axis_tready;
    assign pop               = ~empty & bus.dout_ready;

    always_comb begin
        state_d   = state_q;
        lo_load   = 1'b0;
        push      = 1'b0;
        odd_evt   = 1'b0;
        push_data = '0;
        case (state_q)
            ST_LO: begin
                if (accept) begin
                    if (bus.s_axis_tlast) begin
                        odd_evt = 1'b1;
`ifdef AXIS8_UNPACK_PAD_EN
                        push      = 1'b1;
                        push_data = {1'b1, 8'h00, bus.s_axis_tdata};
`endif
                    end else begin
                        lo_load = 1'b1;
                        state_d = ST_HI;
                    end
                end
            end
            ST_HI: begin
                if (accept) begin
                    push      = 1'b1;
                    push_data = {bus.s_axis_tlast, bus.s_axis_tdata, lo_byte_q};
                    state_d   = ST_LO;
                end
            end
            default: state_d = ST_LO;
        endcase
    end

    always_ff @(posedge CORE_CLK or negedge CORE_RSTN) begin
        if (!CORE_RSTN) begin
            state_q    <= ST_LO;
            lo_byte_q  <= 8'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            word_count <= '0;
            pkt_count  <= '0;
            err_odd    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (lo_load) lo_byte_q <= bus.s_axis_tdata;
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                word_count <= word_count + 1'b1;
                if (push_data[16]) pkt_count <= pkt_count + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (odd_evt) err_odd <= 1'b1;
        end
    end

    // Storage needs no reset; the output is masked while the FIFO is empty.
    always_ff @(posedge CORE_CLK) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign head          = mem[rd_ptr_q[AW-1:0]];
    assign bus.dout      = empty ? 16'h0000 : head[15:0];
    assign bus.dout_last = ~empty & head[16];
    assign bus.dout_valid = ~empty;
    assign level         = wr_ptr_q - rd_ptr_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_axis8_to_stream16.sv
// Self-checking bench for axis8_to_stream16: directed cases plus randomized packets against a byte-pairing model.
module tb_axis8_to_stream16;
  localparam int DEPTH = 16;
  localparam int CNT_BITS = 16;

  logic CORE_CLK;
  logic CORE_RSTN;
  logic [4:0] level;
  logic [CNT_BITS-1:0] word_count, pkt_count;
  logic err_odd, state_dbg;

  axis8_to_stream16_if bus ();

  axis8_to_stream16 #(.DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) dut (
    .CORE_CLK(CORE_CLK), .CORE_RSTN(CORE_RSTN), .bus(bus.slave),
    .level(level), .word_count(word_count), .pkt_count(pkt_count),
    .err_odd(err_odd), .state_dbg(state_dbg)
  );

  // clock / reset
  initial CORE_CLK = 1'b0;
  always #5 CORE_CLK = ~CORE_CLK;

  int n_tests = 0;
  int n_fail = 0;
  int pops = 0;
  bit rand_mode = 0;

  // reference model state
  logic [16:0] exp_q[$];
  logic [7:0] pkt_bytes[$];
  int exp_words = 0;
  int exp_pkts = 0;
  bit exp_err = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endfunction

  // Bytes of a packet pair up in arrival order; a leftover byte at tlast is an odd packet.
  function automatic void model_accept(logic [7:0] b, logic last);
    pkt_bytes.push_back(b);
    if (pkt_bytes.size() == 2) begin
      exp_q.push_back({last, pkt_bytes[1], pkt_bytes[0]});
      exp_words++;
      if (last) exp_pkts++;
      pkt_bytes.delete();
    end else if (last) begin
      exp_err = 1;
`ifdef AXIS8_UNPACK_PAD_EN
      exp_q.push_back({1'b1, 8'h00, b});
      exp_words++;
      exp_pkts++;
`endif
      pkt_bytes.delete();
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    pkt_bytes.delete();
    exp_words = 0;
    exp_pkts = 0;
    exp_err = 0;
  endfunction

  // monitor / scoreboard: sampled mid-cycle, predicts the coming rising edge
  always @(negedge CORE_CLK) begin
    if (CORE_RSTN) begin
      if (bus.dout_valid && bus.dout_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {15'h0, bus.dout_last, bus.dout}, 32'hFFFF_FFFF);
        end else begin
          check("dout_word", {15'h0, bus.dout_last, bus.dout}, {15'h0, exp_q.pop_front()});
        end
        pops++;
      end
      if (bus.s_axis_tvalid && bus.s_axis_tready)
        model_accept(bus.s_axis_tdata, bus.s_axis_tlast);
    end
  end

  // driver tasks
  task automatic wait_cycle();
    @(posedge CORE_CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int cyc = 0;
    bit done = 0;
    bus.s_axis_tdata = b;
    bus.s_axis_tlast = last;
    bus.s_axis_tvalid = 1'b1;
    while (!done) begin
      if (rand_mode) bus.dout_ready = ($urandom_range(0, 3) != 0);
      @(negedge CORE_CLK);
      done = bus.s_axis_tready;
      wait_cycle();
      cyc++;
      if (!done && cyc > 300) begin
        check("send_timeout", 32'd1, 32'd0);
        done = 1;
      end
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    bus.dout_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.dout_valid) && cyc < 1000) begin
      wait_cycle();
      cyc++;
    end
    check("drain_left", exp_q.size(), 0);
    check("drain_level", {27'h0, level}, 0);
  endtask

  task automatic check_counters(string tag);
    check({tag, "_word_count"}, {16'h0, word_count}, exp_words & 32'hFFFF);
    check({tag, "_pkt_count"}, {16'h0, pkt_count}, exp_pkts & 32'hFFFF);
    check({tag, "_err_odd"}, {31'h0, err_odd}, {31'h0, exp_err});
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_tready"}, {31'h0, bus.s_axis_tready}, 0);
    check({tag, "_dout_valid"}, {31'h0, bus.dout_valid}, 0);
    check({tag, "_dout"}, {15'h0, bus.dout_last, bus.dout}, 0);
    check({tag, "_level"}, {27'h0, level}, 0);
    check({tag, "_state"}, {31'h0, state_dbg}, 0);
    check_counters(tag);
  endtask

  initial begin
    int pops0, pkts0;
    bus.s_axis_tdata = 8'h00;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
    bus.dout_ready = 1'b0;
    CORE_RSTN = 1'b0;
    repeat (3) wait_cycle();
    check_reset_outputs("reset");
    @(negedge CORE_CLK);
    CORE_RSTN = 1'b1;
    wait_cycle();
    check("post_reset_tready", {31'h0, bus.s_axis_tready}, 1);

    // basic pair with one-cycle visibility
    bus.dout_ready = 1'b1;
    send_byte(8'h34, 1'b0);
    check("basic_no_push_on_lo", {31'h0, bus.dout_valid}, 0);
    check("basic_state_hi", {31'h0, state_dbg}, 1);
    send_byte(8'h12, 1'b1);
    check("basic_visible", {31'h0, bus.dout_valid}, 1);
    check("basic_dout", {15'h0, bus.dout_last, bus.dout}, 32'h1_1234);
    drain();
    check("basic_wc_const", {16'h0, word_count}, 1);
    check("basic_pc_const", {16'h0, pkt_count}, 1);

    // six-byte packet
    for (int i = 1; i <= 6; i++) send_byte(i[7:0], i == 6);
    drain();
    check_counters("six");

    // backpressure, single pop at full, then release
    bus.dout_ready = 1'b0;
    pops0 = pops;
    pkts0 = exp_pkts;
    for (int i = 0; i < 32; i++) send_byte(8'h40 + i[7:0], 1'b0);
    check("bp_full_level", {27'h0, level}, 16);
    check("bp_full_tready", {31'h0, bus.s_axis_tready}, 0);
    bus.s_axis_tdata = 8'h60;
    bus.s_axis_tvalid = 1'b1;
    repeat (2) wait_cycle();
    check("bp_still_blocked", {31'h0, bus.s_axis_tready}, 0);
    bus.dout_ready = 1'b1;
    wait_cycle();
    bus.dout_ready = 1'b0;
    check("bp_pop_level", {27'h0, level}, 15);
    check("bp_pop_tready", {31'h0, bus.s_axis_tready}, 1);
    send_byte(8'h60, 1'b0);
    check("bp_lo_level", {27'h0, level}, 15);
    send_byte(8'h61, 1'b1);
    check("bp_refill_level", {27'h0, level}, 16);
    check("bp_refill_tready", {31'h0, bus.s_axis_tready}, 0);
    drain();
    check("bp_word_total", pops - pops0, 17);
    check("bp_pkt_delta", exp_pkts - pkts0, 1);
    check_counters("bp");

    // odd packet
    pkts0 = exp_pkts;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    drain();
    check("odd_err_const", {31'h0, err_odd}, 1);
`ifdef AXIS8_UNPACK_PAD_EN
    check("odd_pkt_delta", {16'h0, pkt_count} - pkts0, 1);
`else
    check("odd_pkt_delta", {16'h0, pkt_count} - pkts0, 0);
`endif
    check_counters("odd");

    // asynchronous reset mid-packet
    send_byte(8'h55, 1'b0);
    check("mid_state_hi", {31'h0, state_dbg}, 1);
    CORE_RSTN = 1'b0;
    model_reset();
    repeat (3) wait_cycle();
    check_reset_outputs("mid_reset");
    @(negedge CORE_CLK);
    CORE_RSTN = 1'b1;
    wait_cycle();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    check("mid_dout", {15'h0, bus.dout_last, bus.dout}, 32'h1_2211);
    drain();
    check("mid_wc_const", {16'h0, word_count}, 1);

    // randomized packets with random gaps and backpressure
    rand_mode = 1;
    for (int p = 0; p < 60; p++) begin
      int len;
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.dout_ready = ($urandom_range(0, 1) != 0);
          wait_cycle();
        end
        send_byte($urandom_range(0, 255), k == len - 1);
      end
    end
    rand_mode = 0;
    drain();
    check_counters("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axis8_to_stream16.md
Name: axis8_to_stream16

Overview:
- Receive-side counterpart of the 16-bit-to-AXIS8 output serializer.
- Accepts an AXI4-Stream 8-bit byte stream with TLAST and reassembles byte pairs (low byte first) into 16-bit words with a last flag.
- Buffers the words in a show-ahead FIFO and presents them on a 16-bit valid/ready interface.
- Used on the host/loopback side of the bcrypt LiteX integration to consume output packets, and by benches to check the output path.

Parameters:
- DEPTH, 16, FIFO depth in 16-bit words; power of two, minimum 2.
- CNT_BITS, 16, width of the word and packet counters.

Ports:
- CORE_CLK  input  1  single clock; all logic on its rising edge.
- CORE_RSTN  input  1  asynchronous active-low reset.
- s_axis_tdata  input  8  input byte.
- s_axis_tvalid  input  1  input byte valid.
- s_axis_tready  output  1  block can accept a byte.
- s_axis_tlast  input  1  byte is the last of its packet.
- dout  output  16  assembled word, {high byte, low byte}.
- dout_valid  output  1  FIFO not empty.
- dout_ready  input  1  consumer pops the word shown on dout.
- dout_last  output  1  word carries the packet's final byte.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- word_count  output  CNT_BITS  words pushed since reset; wraps.
- pkt_count  output  CNT_BITS  packets completed (last word pushed) since reset; wraps.
- err_odd  output  1  sticky flag: a packet ended on a low byte.

Behaviour:
- Reset (asynchronous, CORE_RSTN=0):
  - Assembler returns to LO; partial byte register cleared.
  - FIFO emptied; counters 0; err_odd 0.
  - Outputs: dout_valid 0, dout_last 0, dout 0, level 0, s_axis_tready 0 while reset is asserted.
- Reset deasserted mid-packet: the remainder of that packet is treated as a new packet starting at LO. No recovery is attempted.
- Handshake: a byte is accepted when s_axis_tvalid & s_axis_tready. A word is popped when dout_valid & dout_ready.
- s_axis_tready = ~full. This holds in both assembler states, so a byte is never accepted without room for the word it may complete.
- Assembler FSM, state LO:
  - Accepted byte with tlast=0: latch into lo_byte, go to HI. No push.
  - Accepted byte with tlast=1: odd packet. Behaviour depends on the optional feature; state stays LO.
- Assembler FSM, state HI:
  - Accepted byte: push {tdata, lo_byte} with last=tlast; go to LO.
  - word_count increments on every push.
  - pkt_count increments when the pushed word has last=1.
- FIFO:
  - DEPTH x 17 bits, {last, word}; read and write pointers are $clog2(DEPTH)+1 bits.
  - full when pointers differ only in the MSB; empty when equal.
  - Show-ahead: dout/dout_last reflect the head entry combinationally; dout_valid = ~empty.
  - Latency: a word is visible on dout the cycle after its high byte is accepted. There is no bypass.
  - Simultaneous push and pop: both happen and level is unchanged. This is legal even when full, but s_axis_tready already reflects full, so no push occurs while full.
  - Pop while empty: ignored. Pointers wrap naturally.
- Counters wrap modulo 2^CNT_BITS without saturation.
- err_odd is set on every odd-packet event and stays set until reset. It is not cleared by traffic.

Optional Feature:
- Macro: AXIS8_UNPACK_PAD_EN.
- Defined: an odd-packet byte (LO, tlast=1) pushes {8'h00, tdata} with last=1. word_count and pkt_count increment; err_odd is still set.
- Undefined: the odd byte is dropped with no push and no counter change; err_odd is set.

Test Plan:
- Basic pair: bytes 0x34, 0x12(tlast) with dout_ready=1 -> one word dout=0x1234, dout_last=1, visible 1 cycle after the 0x12 accept; word_count=1, pkt_count=1.
- 6-byte packet 01..06 (tlast on 06) -> words 0x0201, 0x0403, 0x0605; last only on 0x0605; pkt_count=1.
- Backpressure: dout_ready=0, stream 2*DEPTH+2 bytes (DEPTH=16 -> 34):
  - s_axis_tready drops after 32 bytes, with level=16 and the final 2 bytes still pending.
  - Release dout_ready: all 17 words arrive in order; none lost or duplicated.
- Odd packet: bytes 0xAA, 0xBB, 0xCC(tlast) ->
  - Without AXIS8_UNPACK_PAD_EN: word 0xBBAA with last=0, err_odd=1, pkt_count=0.
  - With AXIS8_UNPACK_PAD_EN: words 0xBBAA, then 0x00CC with last=1; pkt_count=1; err_odd=1.
- Simultaneous push/pop at level=16: pop and high-byte accept are not coincident because tready=0. Pop a word and verify tready returns the next cycle; level goes 16 -> 15 -> 16 after the next push.
- Async reset mid-packet after byte 0x55: assert CORE_RSTN=0 for 3 cycles -> level=0, counters=0, err_odd=0. Then send 0x11, 0x22(tlast) -> dout=0x2211 (0x55 discarded).
